// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants shared by the timing generator and the renderers.
// Derived totals and sync windows follow from the porch/sync widths below.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam logic SYNC_ACTIVE = 1'b0;
    localparam int   ANIM_DIV    = 4;

    localparam int H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HSYNC_START = H_VISIBLE + H_FRONT;
    localparam int HSYNC_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VSYNC_START = V_VISIBLE + V_FRONT;
    localparam int VSYNC_END   = V_VISIBLE + V_FRONT + V_SYNC;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous active-low reset; wrap flags the
// enabled cycle that returns the count to zero so it can chain the next stage.
module wrap_counter #(
    parameter int W   = 10,
    parameter int MAX = 1023
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_value,
    output logic         o_wrap
);

    logic [W-1:0] r_value;

    assign o_value = r_value;
    assign o_wrap  = i_en && (r_value == W'(MAX));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_value <= '0;
        end else if (i_en) begin
            r_value <= o_wrap ? '0 : r_value + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: position counters, registered syncs/active, frame count and pulses.
// Syncs and video_active are precomputed from next-state counters so they stay aligned with pix_x/pix_y.
module vga_timing_gen #(
    parameter int   H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int   H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK      = vga_timing_pkg::H_BACK,
    parameter int   V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int   V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK      = vga_timing_pkg::V_BACK,
    parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE,
    parameter int   ANIM_DIV    = vga_timing_pkg::ANIM_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic       hsync,
    output logic       vsync,
    output logic       video_active,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] counter,
    output logic       anim_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (ANIM_DIV < 1) begin : g_bad_anim
        $error("vga_timing_gen: ANIM_DIV must be at least 1");
    end

    logic [9:0] w_h_cnt, w_v_cnt, w_frame_cnt, w_anim_cnt;
    logic       w_h_wrap, w_v_wrap, w_frame_wrap, w_anim_wrap;
    logic [9:0] w_h_nxt, w_v_nxt;
    logic       w_unused;
    logic       r_hsync, r_vsync, r_video, r_adv;

    wrap_counter #(.W(10), .MAX(H_TOTAL - 1)) u_h_cnt (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(ena),
        .o_value(w_h_cnt), .o_wrap(w_h_wrap)
    );

    wrap_counter #(.W(10), .MAX(V_TOTAL - 1)) u_v_cnt (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(w_h_wrap),
        .o_value(w_v_cnt), .o_wrap(w_v_wrap)
    );

    wrap_counter #(.W(10), .MAX(1023)) u_frame_cnt (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(w_v_wrap),
        .o_value(w_frame_cnt), .o_wrap(w_frame_wrap)
    );

    wrap_counter #(.W(10), .MAX(ANIM_DIV - 1)) u_anim_cnt (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(w_v_wrap),
        .o_value(w_anim_cnt), .o_wrap(w_anim_wrap)
    );

    assign w_unused = &{1'b0, w_frame_wrap, w_anim_wrap};

    // Mirror of the counter update, used to precompute the registered syncs.
    always_comb begin
        w_h_nxt = w_h_cnt;
        w_v_nxt = w_v_cnt;
        if (ena) begin
            w_h_nxt = w_h_wrap ? 10'd0 : w_h_cnt + 10'd1;
        end
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? 10'd0 : w_v_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
            r_video <= 1'b1;
            r_adv   <= 1'b1;
        end else begin
            r_hsync <= (w_h_nxt >= HS_START && w_h_nxt < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync <= (w_v_nxt >= VS_START && w_v_nxt < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_video <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
            r_adv   <= ena;
        end
    end

    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign video_active = r_video;
    assign pix_x        = w_h_cnt;
    assign pix_y        = w_v_cnt;
    assign counter      = w_frame_cnt;

    // r_adv keeps pulses from repeating while frozen on x==0.
    assign line_start  = rst_n && r_adv && (w_h_cnt == 10'd0);
    assign frame_start = line_start && (w_v_cnt == 10'd0);
    assign anim_tick   = frame_start && (w_anim_cnt == 10'd0);

endmodule
